// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states,
// output-buffer entry layout and the NOP used for faulting fetches.
package ifetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DRAIN
   } ifetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            fault;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry output buffer between fetch and decode.
// Ports: clk/rst, push_i+data_i, pop_i, flush_i (clears all entries),
// data_o (head entry), full_o, empty_o.
module ifetch_fifo
   import ifetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  fetch_entry_t data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output fetch_entry_t data_o,
   output logic         full_o,
   output logic         empty_o
);

   fetch_entry_t mem_q [2];
   logic         wr_q;
   logic         rd_q;
   logic [1:0]   cnt_q;
   logic         do_push;
   logic         do_pop;

   assign full_o  = (cnt_q == 2'd2);
   assign empty_o = (cnt_q == 2'd0);
   assign do_pop  = pop_i && !empty_o;
   // A push into a full buffer is fine when the head leaves this cycle.
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rd_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else if (flush_i) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= ~wr_q;
         end
         if (do_pop) begin
            rd_q <= ~rd_q;
         end
         cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding memory transaction, 2-entry
// output buffer, flush support. Ports: pc_i/pc_valid_i/pc_ready_o from
// the PC stage, imem_* request/response, out_* towards decode, flush_i.
// Optional IFETCH_MISALIGN_CHECK_EN: misaligned PCs push a faulting NOP.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pc_i,
   input  logic                  pc_valid_i,
   output logic                  pc_ready_o,
   input  logic                  flush_i,
   output logic                  imem_req_o,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_instr_o,
   output logic [DATA_WIDTH-1:0] out_pc_o,
   output logic                  out_fault_o
);

   ifetch_state_e         state_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic                  req_q;
   logic                  fifo_full;
   logic                  fifo_empty;
   fetch_entry_t          push_ent;
   fetch_entry_t          head;
   logic                  fault_push;
   logic                  accept;
   logic                  resp_done;
   logic                  push;
   logic                  pop;

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic mis_q;
   // A misaligned PC parks in WAIT for one cycle and pushes a NOP.
   assign fault_push = (state_q == WAIT) && mis_q;
`else
   assign fault_push = 1'b0;
`endif

   assign pc_ready_o = !rst && (state_q == IDLE)
                       && !fifo_full && !flush_i;
   assign accept     = pc_valid_i && pc_ready_o;
   assign resp_done  = (state_q == WAIT)
                       && (imem_rvalid_i || fault_push);
   assign push       = resp_done && !flush_i;
   assign pop        = out_valid_o && out_ready_i;

   always_comb begin
      push_ent       = '0;
      push_ent.instr = fault_push ? NOP : imem_rdata_i;
      push_ent.pc    = pc_q;
      push_ent.fault = fault_push;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         req_q   <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  pc_q <= pc_i;
`ifdef IFETCH_MISALIGN_CHECK_EN
                  if (|pc_i[1:0]) begin
                     mis_q   <= 1'b1;
                     state_q <= WAIT;
                  end else begin
                     mis_q   <= 1'b0;
                     req_q   <= 1'b1;
                     state_q <= REQ;
                  end
`else
                  req_q   <= 1'b1;
                  state_q <= REQ;
`endif
               end
            end
            REQ: begin
               if (flush_i) begin
                  req_q   <= 1'b0;
                  state_q <= imem_gnt_i ? DRAIN : IDLE;
               end else if (imem_gnt_i) begin
                  req_q   <= 1'b0;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (resp_done) begin
                  state_q <= IDLE;
               end else if (flush_i) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (imem_rvalid_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   ifetch_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (push_ent),
      .pop_i   (pop),
      .flush_i (flush_i),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign imem_req_o  = req_q;
   assign imem_addr_o = pc_q;
   assign out_valid_o = !fifo_empty;
   assign out_instr_o = head.instr;
   assign out_pc_o    = head.pc;
   assign out_fault_o = head.fault;

endmodule
